// File: rtl/ram_dma.sv
// Block-copy / block-fill bus master for a single-port synchronous RAM.
// Copy alternates read/write cycles word by word; fill writes one word per cycle.
module ram_dma #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] src,
  input  logic [A-1:0] dst,
  input  logic [A:0]   len,
  input  logic [D-1:0] fill_val,
  output logic         busy,
  output logic         done,
  output logic         ram_cs,
  output logic         ram_rw,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_di,
  input  logic [D-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FILL = 2'd3} state_t;

  state_t       state_q, state_d;
  logic [A-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [A:0]   rem_q, rem_d;
  logic [D-1:0] fill_q, fill_d, di_q, di_d;
  logic         done_q, done_d;
  logic         last;

  assign last = (rem_q == (A+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && (len != '0)) state_d = mode ? FILL : RD;
      RD:   state_d = WR;
      WR:   state_d = last ? IDLE : RD;
      FILL: state_d = last ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  // Transfer counters and latched parameters; addr/di hold registers keep IDLE outputs stable.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    rem_d  = rem_q;
    fill_d = fill_q;
    done_d = 1'b0;
    addr_d = ram_addr;
    di_d   = ram_di;
    unique case (state_q)
      IDLE: if (start) begin
        src_d  = src;
        dst_d  = dst;
        rem_d  = len;
        fill_d = fill_val;
        done_d = (len == '0);
      end
      WR: begin
        src_d  = src_q + 1'b1;
        dst_d  = dst_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        done_d = last;
      end
      FILL: begin
        dst_d  = dst_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        done_d = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      fill_q <= '0;
      addr_q <= '0;
      di_q   <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      rem_q  <= rem_d;
      fill_q <= fill_d;
      addr_q <= addr_d;
      di_q   <= di_d;
      done_q <= done_d;
    end
  end

  // RAM strobes and address come from registered state only; write data
  // in WR is the word the RAM registered on the preceding read edge.
  always_comb begin
    ram_cs   = 1'b0;
    ram_rw   = 1'b0;
    ram_addr = addr_q;
    ram_di   = di_q;
    unique case (state_q)
      RD: begin
        ram_cs   = 1'b1;
        ram_addr = src_q;
      end
      WR: begin
        ram_cs   = 1'b1;
        ram_rw   = 1'b1;
        ram_addr = dst_q;
        ram_di   = ram_dout;
      end
      FILL: begin
        ram_cs   = 1'b1;
        ram_rw   = 1'b1;
        ram_addr = dst_q;
        ram_di   = fill_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: behavioural RAM, write scoreboard fed by a reference copy/fill model.
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  src = '0, dst = '0;
  logic [10:0] len = '0;
  logic [7:0]  fill_val = '0;
  logic        busy, done, ram_cs, ram_rw;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_dout;

  ram_dma #(.A(10), .D(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .ram_cs(ram_cs),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a preload port used only while the DMA is idle.
  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       pk_en = 1'b0;
  logic [9:0] pk_addr = '0;
  logic [7:0] pk_val = '0;

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_val;
    else if (ram_cs) begin
      if (ram_rw) mem[ram_addr] <= ram_di;
      else        ram_dout <= mem[ram_addr];
    end
  end

  // Monitor: counts and logs observed write transactions.
  int         busy_cnt = 0, cs_cnt = 0, done_cnt = 0, done_busy_cnt = 0;
  logic [17:0] act_buf [0:255];
  int         act_wr = 0;
  int         act_rd = 0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (ram_cs) cs_cnt++;
    if (done) begin
      done_cnt++;
      if (busy) done_busy_cnt++;
    end
    if (ram_cs && ram_rw) begin
      act_buf[act_wr % 256] = {ram_addr, ram_di};
      act_wr++;
    end
  end

  logic [17:0] exp_q [$];
  int    errors = 0, checks = 0;
  string cur_test = "";

  task automatic poke(input logic [9:0] a, input logic [7:0] v);
    pk_addr = a; pk_val = v; pk_en = 1'b1;
    ref_mem[a] = v;
    @(posedge clk); #1;
    pk_en = 1'b0;
    @(negedge clk); #1;
  endtask

  // Reference model: ascending word-by-word read-then-write on ref_mem.
  task automatic model_xfer(input logic m, input logic [9:0] s, input logic [9:0] d,
                            input logic [7:0] f, input int nwords);
    logic [7:0] v;
    for (int k = 0; k < nwords; k++) begin
      v = m ? f : ref_mem[s];
      ref_mem[d] = v;
      exp_q.push_back({d, v});
      s = s + 10'd1;
      d = d + 10'd1;
    end
  endtask

  // Advance one cycle and score every write the DUT produced.
  task automatic step();
    logic [17:0] a, e;
    @(negedge clk); #1;
    while (act_rd < act_wr) begin
      a = act_buf[act_rd % 256];
      act_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s extra_write got addr=%h data=%h expected none", cur_test, a[17:8], a[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s write got addr=%h data=%h expected addr=%h data=%h",
                   cur_test, a[17:8], a[7:0], e[17:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic begin_xfer(input logic m, input logic [9:0] s, input logic [9:0] d,
                            input logic [10:0] n, input logic [7:0] f);
    mode = m; src = s; dst = d; len = n; fill_val = f; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) step();
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s done_timeout got no done expected done within %0d cycles", cur_test, budget);
    end
  endtask

  task automatic check_int(input string what, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %0d expected %0d", cur_test, what, got, want);
    end
  endtask

  task automatic check_sb_and_mem();
    int bad = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got %0d pending expected 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mem_image got %0d differing words expected 0", cur_test, bad);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    #3;
    checks++;
    if ({busy, done, ram_cs, ram_rw, ram_addr, ram_di} !== 22'd0) begin
      errors++;
      $display("FAIL reset outputs got %b expected all zero", {busy, done, ram_cs, ram_rw, ram_addr, ram_di});
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_copy();
    int b0, d0;
    cur_test = "copy";
    poke(10'h010, 8'h11); poke(10'h011, 8'h22); poke(10'h012, 8'h33); poke(10'h013, 8'h44);
    b0 = busy_cnt; d0 = done_cnt;
    model_xfer(1'b0, 10'h010, 10'h100, 8'h00, 4);
    begin_xfer(1'b0, 10'h010, 10'h100, 11'd4, 8'h00);
    run_until_done(40);
    check_int("busy_cycles", busy_cnt - b0, 8);
    check_int("done_pulses", done_cnt - d0, 1);
    check_int("done_with_busy", done_busy_cnt, 0);
    step();
    check_int("done_width", done_cnt - d0, 1);
    check_int("idle_cs", int'(ram_cs), 0);
    check_int("hold_addr", int'(ram_addr), 'h103);
    check_int("hold_di", int'(ram_di), 'h44);
    check_int("dst_word3", int'(mem[10'h103]), 'h44);
    check_sb_and_mem();
  endtask

  task automatic test_fill();
    int b0;
    cur_test = "fill";
    poke(10'h1FF, 8'h77); poke(10'h203, 8'h88);
    b0 = busy_cnt;
    model_xfer(1'b1, 10'h000, 10'h200, 8'hA5, 3);
    begin_xfer(1'b1, 10'h000, 10'h200, 11'd3, 8'hA5);
    run_until_done(40);
    check_int("busy_cycles", busy_cnt - b0, 3);
    step();
    check_int("below_untouched", int'(mem[10'h1FF]), 'h77);
    check_int("above_untouched", int'(mem[10'h203]), 'h88);
    check_int("fill_word1", int'(mem[10'h201]), 'hA5);
    check_sb_and_mem();
  endtask

  task automatic test_wrap();
    cur_test = "wrap";
    poke(10'h3FE, 8'h01); poke(10'h3FF, 8'h02); poke(10'h000, 8'h03);
    model_xfer(1'b0, 10'h3FE, 10'h3FF, 8'h00, 3);
    begin_xfer(1'b0, 10'h3FE, 10'h3FF, 11'd3, 8'h00);
    run_until_done(40);
    step();
    check_int("wrap_3ff", int'(mem[10'h3FF]), 'h01);
    check_int("wrap_000", int'(mem[10'h000]), 'h01);
    check_int("wrap_001", int'(mem[10'h001]), 'h01);
    check_sb_and_mem();
  endtask

  task automatic test_len0_and_ignore();
    int b0, c0, d0;
    cur_test = "len0";
    b0 = busy_cnt; c0 = cs_cnt; d0 = done_cnt;
    begin_xfer(1'b0, 10'h050, 10'h150, 11'd0, 8'h00);
    check_int("done_next_cycle", done_cnt - d0, 1);
    for (int i = 0; i < 4; i++) step();
    check_int("single_done", done_cnt - d0, 1);
    check_int("no_cs", cs_cnt - c0, 0);
    check_int("no_busy", busy_cnt - b0, 0);

    cur_test = "ignore";
    b0 = busy_cnt;
    model_xfer(1'b1, 10'h000, 10'h300, 8'h5A, 5);
    begin_xfer(1'b1, 10'h000, 10'h300, 11'd5, 8'h5A);
    step();
    mode = 1'b0; src = 10'h000; dst = 10'h010; len = 11'd2; fill_val = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(40);
    check_int("busy_cycles", busy_cnt - b0, 5);
    step();
    check_sb_and_mem();
  endtask

  task automatic test_back_to_back();
    int b0, d0;
    cur_test = "back_to_back";
    poke(10'h020, 8'h9A); poke(10'h021, 8'h9B);
    b0 = busy_cnt; d0 = done_cnt;
    model_xfer(1'b0, 10'h020, 10'h120, 8'h00, 2);
    begin_xfer(1'b0, 10'h020, 10'h120, 11'd2, 8'h00);
    run_until_done(40);
    model_xfer(1'b1, 10'h000, 10'h220, 8'h3C, 3);
    begin_xfer(1'b1, 10'h000, 10'h220, 11'd3, 8'h3C);
    check_int("second_busy_now", int'(busy), 1);
    run_until_done(40);
    check_int("busy_cycles", busy_cnt - b0, 7);
    check_int("done_pulses", done_cnt - d0, 2);
    step();
    check_sb_and_mem();
  endtask

  task automatic test_reset_mid_copy();
    int d0;
    cur_test = "reset_mid";
    for (int i = 0; i < 8; i++) poke(10'h040 + 10'(i), 8'h60 + 8'(i));
    for (int i = 0; i < 8; i++) poke(10'h140 + 10'(i), 8'hE0 + 8'(i));
    d0 = done_cnt;
    model_xfer(1'b0, 10'h040, 10'h140, 8'h00, 2);
    begin_xfer(1'b0, 10'h040, 10'h140, 11'd8, 8'h00);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ram_cs, ram_rw, ram_addr, ram_di} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b expected all zero", {busy, done, ram_cs, ram_rw, ram_addr, ram_di});
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check_int("no_done", done_cnt - d0, 0);
    check_int("word2_untouched", int'(mem[10'h142]), 'hE2);
    check_sb_and_mem();

    cur_test = "after_reset";
    model_xfer(1'b1, 10'h000, 10'h150, 8'hC3, 2);
    begin_xfer(1'b1, 10'h000, 10'h150, 11'd2, 8'hC3);
    run_until_done(40);
    step();
    check_sb_and_mem();
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len0_and_ignore();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
